// File: rtl/psum_accum_pkg.sv
// Shared constants and signed types for the partial-sum accumulator.
// Read by psum_accum and psum_sat; the PSUM_ACCUM_SAT_EN build option lives in those files.
package psum_pkg;
    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 6;
    localparam int MAX_LEN = 16;
    localparam int LEN_BW  = 5;
    localparam int CNT_BW  = $clog2(MAX_LEN);
    localparam int ACC_BW  = BW_PSUM + $clog2(MAX_LEN);
    localparam int OUT_BW  = 24;

    typedef logic signed [BW_PSUM-1:0] psum_t;
    typedef logic signed [ACC_BW-1:0]  acc_t;
    typedef logic signed [OUT_BW-1:0]  out_t;

    // Zero is treated as one chunk; anything above MAX_LEN is clamped to MAX_LEN.
    function automatic logic [LEN_BW-1:0] clamp_len(input logic [LEN_BW-1:0] len);
        logic [LEN_BW-1:0] res;
        res = len;
        if (len == '0) begin
            res = LEN_BW'(1);
        end else if (len > LEN_BW'(MAX_LEN)) begin
            res = LEN_BW'(MAX_LEN);
        end
        return res;
    endfunction
endpackage

// File: rtl/psum_accum_sat.sv
// Accumulator-to-output converter: saturates when PSUM_ACCUM_SAT_EN is defined, else wraps.
// clamp_o reports that the value did not fit in OUT_BW bits.
module psum_sat
    import psum_pkg::*;
(
    input  acc_t acc_i,
    output out_t data_o,
    output logic clamp_o
);
    // The value fits only when every bit from OUT_BW-1 upward equals the sign bit.
    logic [ACC_BW-OUT_BW:0] top_bits;
    logic                   ovf_pos;
    logic                   ovf_neg;

    assign top_bits = acc_i[ACC_BW-1:OUT_BW-1];
    assign ovf_pos  = ~top_bits[ACC_BW-OUT_BW] & (|top_bits);
    assign ovf_neg  = top_bits[ACC_BW-OUT_BW] & ~(&top_bits);
    assign clamp_o  = ovf_pos | ovf_neg;

`ifdef PSUM_ACCUM_SAT_EN
    always_comb begin
        data_o = acc_i[OUT_BW-1:0];
        if (ovf_pos) begin
            data_o = {1'b0, {(OUT_BW-1){1'b1}}};
        end else if (ovf_neg) begin
            data_o = {1'b1, {(OUT_BW-1){1'b0}}};
        end
    end
`else
    assign data_o = acc_i[OUT_BW-1:0];
`endif
endmodule

// File: rtl/psum_accum.sv
// Two-stage accumulator: registers MAC partial sums and sums LEN of them per dot product.
// Defining PSUM_ACCUM_SAT_EN saturates the result and adds the sat_flag output.
module psum_accum
    import psum_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LEN_BW-1:0]  cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW_PSUM-1:0] in_psum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_BW-1:0]  out_data,
`ifdef PSUM_ACCUM_SAT_EN
    output logic               sat_flag,
`endif
    output logic               busy
);
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic [LEN_BW-1:0] len_q, len_d;
    psum_t             r1_psum_q, r1_psum_d;
    logic              r1_v_q, r1_v_d;
    logic              r1_first_q, r1_first_d;
    logic              r1_last_q, r1_last_d;
    acc_t              acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    out_t              out_data_q, out_data_d;
`ifdef PSUM_ACCUM_SAT_EN
    logic              sat_q, sat_d;
`endif

    logic              stall;
    logic              accept;
    logic [LEN_BW-1:0] len_sel;
    logic              is_last;
    acc_t              acc_base;
    acc_t              acc_n;
    out_t              conv_data;
    logic              conv_clamp;

    psum_sat u_sat (
        .acc_i   (acc_n),
        .data_o  (conv_data),
        .clamp_o (conv_clamp)
    );

    always_comb begin
        stall    = out_valid_q & ~out_ready;
        accept   = in_valid & ~stall;
        // A new group samples cfg_len now; later beats keep the length latched at its start.
        len_sel  = (cnt_q == '0) ? clamp_len(cfg_len) : len_q;
        is_last  = (LEN_BW'(cnt_q) == (len_sel - LEN_BW'(1)));
        acc_base = r1_first_q ? '0 : acc_q;
        acc_n    = acc_base + {{(ACC_BW-BW_PSUM){r1_psum_q[BW_PSUM-1]}}, r1_psum_q};

        cnt_d       = cnt_q;
        len_d       = len_q;
        r1_psum_d   = r1_psum_q;
        r1_v_d      = r1_v_q;
        r1_first_d  = r1_first_q;
        r1_last_d   = r1_last_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef PSUM_ACCUM_SAT_EN
        sat_d       = sat_q;
`endif

        if (!stall) begin
            r1_v_d = accept;
            if (accept) begin
                r1_psum_d  = in_psum;
                r1_first_d = (cnt_q == '0);
                r1_last_d  = is_last;
                cnt_d      = is_last ? '0 : cnt_q + CNT_BW'(1);
                len_d      = len_sel;
            end
            // Not stalled means any current result is being taken, so a new one lands bubble-free.
            out_valid_d = r1_v_q & r1_last_q;
            if (r1_v_q) begin
                acc_d = acc_n;
                if (r1_last_q) begin
                    out_data_d = conv_data;
`ifdef PSUM_ACCUM_SAT_EN
                    sat_d      = conv_clamp;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            len_q       <= LEN_BW'(1);
            r1_psum_q   <= '0;
            r1_v_q      <= 1'b0;
            r1_first_q  <= 1'b0;
            r1_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef PSUM_ACCUM_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            r1_psum_q   <= r1_psum_d;
            r1_v_q      <= r1_v_d;
            r1_first_q  <= r1_first_d;
            r1_last_q   <= r1_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef PSUM_ACCUM_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0) | r1_v_q | out_valid_q;

`ifdef PSUM_ACCUM_SAT_EN
    assign sat_flag = sat_q;
`else
    logic unused_clamp;
    assign unused_clamp = conv_clamp;
`endif
endmodule

// File: tb/tb_psum_accum.sv
// Testbench for psum_accum: group-level reference model checked every cycle plus literal results.
// Define PSUM_ACCUM_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_psum_accum;
    import psum_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [LEN_BW-1:0]  cfg_len;
    logic               in_valid;
    logic               in_ready;
    logic [BW_PSUM-1:0] in_psum;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_BW-1:0]  out_data;
    logic               busy;
`ifdef PSUM_ACCUM_SAT_EN
    logic               sat_flag;
`endif

    psum_accum dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PSUM_ACCUM_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Result of a finished group as it must appear on out_data.
    function automatic void conv(input longint s, output longint v, output bit f);
        longint lim;
        lim = 64'sd1 << (OUT_BW - 1);
`ifdef PSUM_ACCUM_SAT_EN
        f = 1'b1;
        if (s > lim - 1)    v = lim - 1;
        else if (s < -lim)  v = -lim;
        else begin v = s; f = 1'b0; end
`else
        f = (s > lim - 1) || (s < -lim);
        v = s & ((64'sd1 << OUT_BW) - 1);
        if (v >= lim) v = v - (lim << 1);
`endif
    endfunction

    // Reference: groups are summed as beats arrive; a finished sum takes two unstalled cycles to show.
    int     m_cnt, m_len;
    longint m_sum;
    bit     m_mid_v, m_mid_res, m_mid_sat;
    longint m_mid_val;
    bit     m_ov, m_sat;
    longint m_od;
    bit     started = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_cnt = 0; m_len = 1; m_sum = 0;
            m_mid_v = 0; m_mid_res = 0; m_mid_val = 0; m_mid_sat = 0;
            m_ov = 0; m_od = 0; m_sat = 0;
        end else if (!(m_ov && !out_ready)) begin
            m_ov = m_mid_v && m_mid_res;
            if (m_ov) begin m_od = m_mid_val; m_sat = m_mid_sat; end
            m_mid_v = in_valid;
            m_mid_res = 0;
            if (in_valid) begin
                if (m_cnt == 0) begin
                    m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
                    m_sum = 0;
                end
                m_sum = m_sum + longint'($signed(in_psum));
                m_cnt++;
                if (m_cnt == m_len) begin
                    conv(m_sum, m_mid_val, m_mid_sat);
                    m_mid_res = 1;
                    m_cnt = 0;
                end
            end
        end
        started = 1'b1;
    end

    int res_q[$];
    bit sat_q[$];

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, !(m_ov && !out_ready));
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, (m_cnt != 0) || m_mid_v || m_ov);
            if (m_ov) begin
                chk("out_data", longint'($signed(out_data)), m_od);
`ifdef PSUM_ACCUM_SAT_EN
                chk("sat_flag", sat_flag, m_sat);
`endif
            end
            if (out_valid && out_ready) begin
                res_q.push_back(int'($signed(out_data)));
`ifdef PSUM_ACCUM_SAT_EN
                sat_q.push_back(sat_flag);
`else
                sat_q.push_back(1'b0);
`endif
            end
        end
    end

    task automatic send(input int p);
        bit done;
        in_valid = 1'b1;
        in_psum  = BW_PSUM'(p);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        reset_n = 1'b0; cfg_len = 1; in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);

        // Reset mid-group discards the partial sum.
        cfg_len = 3; send(10); send(20);
        reset_n = 1'b0; idle(2); reset_n = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_no_result", res_q.size(), 0);
        @(posedge clk); #1;
        cfg_len = 2; send(5); send(7); idle(3);
        chk("len2_count", res_q.size(), 1);
        chk("len2_sum", res_q[$], 12);

        // LEN=4 mixed signs.
        base = res_q.size();
        cfg_len = 4; send(100); send(-300); send(50); send(-1); idle(4);
        chk("len4_count", res_q.size() - base, 1);
        chk("len4_sum", res_q[$], -151);

        // LEN=1 streaming, no bubbles (model checks in_ready/out_valid each cycle).
        base = res_q.size();
        cfg_len = 1;
        for (int i = 1; i <= 8; i++) send(i);
        idle(3);
        chk("stream_count", res_q.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("stream_val", res_q[base + i], i + 1);

        // Back-pressure: hold out_ready low for 5 cycles once the first result is up.
        base = res_q.size();
        cfg_len = 2; out_ready = 1'b0;
        fork
            begin
                send(11); send(22); send(3); send(4);
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                chk("bp_result_seen", seen, 1);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_held_data", longint'($signed(out_data)), 33);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_count", res_q.size() - base, 2);
        chk("bp_first", res_q[base], 33);
        chk("bp_second", res_q[base + 1], 7);

        // cfg_len=0 means 1; mid-group length change is ignored.
        base = res_q.size();
        cfg_len = 0; send(9); send(-9);
        cfg_len = 3; send(1); cfg_len = 2; send(2); send(4);
        send(10); send(20); idle(4);
        chk("cfg_count", res_q.size() - base, 4);
        chk("len0_a", res_q[base], 9);
        chk("len0_b", res_q[base + 1], -9);
        chk("len_change", res_q[base + 2], 7);
        chk("len_next", res_q[base + 3], 30);

        // Overflow in both directions at LEN=16.
        base = res_q.size();
        cfg_len = 16;
        for (int i = 0; i < 16; i++) send(2097151);
        for (int i = 0; i < 16; i++) send(-2097152);
        idle(4);
        chk("ovf_count", res_q.size() - base, 2);
`ifdef PSUM_ACCUM_SAT_EN
        chk("ovf_pos_data", res_q[base], 8388607);
        chk("ovf_pos_flag", sat_q[base], 1);
        chk("ovf_neg_data", res_q[base + 1], -8388608);
        chk("ovf_neg_flag", sat_q[base + 1], 1);
`else
        chk("ovf_pos_data", res_q[base], -16);
        chk("ovf_neg_data", res_q[base + 1], 0);
`endif
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
